// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port and the load/store port, one transaction at a time.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_owner_ls;
  logic                r_last_ls;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_cnt;
  logic                r_if_rvalid;
  logic                r_ls_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                w_any_req;
  logic                w_pick_ls;

  assign w_any_req = if_req | ls_req;
  // On a tie the port that did not own the previous transaction wins.
  assign w_pick_ls = ls_req & (~if_req | ~r_last_ls);

  always_comb begin
    w_state_next = r_state;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if_gnt       = 1'b0;
    ls_gnt       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any_req) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        if_gnt       = ~r_owner_ls;
        ls_gnt       = r_owner_ls;
        w_state_next = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner_ls  <= 1'b0;
      r_last_ls   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_ls <= w_pick_ls;
            r_last_ls  <= w_pick_ls;
            r_we       <= w_pick_ls & ls_we;
            r_addr     <= w_pick_ls ? ls_addr : if_addr;
            r_wdata    <= w_pick_ls ? ls_wdata : '0;
          end
        end
        S_ISSUE: r_cnt <= LAT_M1;
        S_WAIT: begin
          // Count 0 is the cycle the RAM presents the read data.
          if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else if (r_owner_ls) begin
            r_ls_rdata  <= mem_rdata;
            r_ls_rvalid <= 1'b1;
          end else begin
            r_if_rdata  <= mem_rdata;
            r_if_rvalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at RD_LAT=1 and one at
// RD_LAT=3, each with a behavioural RAM returning a fixed address-derived pattern.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        if_req1, ls_req1, ls_we1, if_req3, ls_req3, ls_we3;
  logic [31:0] if_addr1, ls_addr1, ls_wdata1, if_addr3, ls_addr3, ls_wdata3;
  logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, mem_en1, mem_we1, busy1;
  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [31:0] p0, p1, p2;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .ls_req(ls_req1), .ls_we(ls_we1), .ls_addr(ls_addr1), .ls_wdata(ls_wdata1),
    .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h80:  return 32'hCAFEF00D;
      default: return {a[15:0], 16'h5A5A};
    endcase
  endfunction

  // RAM models: read data valid exactly RD_LAT cycles after mem_en, junk otherwise.
  always @(posedge clk) begin
    mem_rdata1 <= (mem_en1 && !mem_we1) ? mem_val(mem_addr1) : 32'hBAD0_0001;
    p0 <= (mem_en3 && !mem_we3) ? mem_val(mem_addr3) : 32'hBAD0_0003;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          pend;
  logic        pend_ls;
  logic [31:0] pend_addr;

  initial begin
    reset = 1'b1;
    {if_req1, ls_req1, ls_we1, if_req3, ls_req3, ls_we3} = '0;
    {if_addr1, ls_addr1, ls_wdata1, if_addr3, ls_addr3, ls_wdata3} = '0;
    pend = 0; pend_ls = 1'b0; pend_addr = '0;
    step(); step();
    chk("rst_busy", busy1, 0);
    chk("rst_gnt", {if_gnt1, ls_gnt1}, 0);
    chk("rst_mem_en", mem_en1, 0);
    chk("rst_if_rdata", if_rdata1, 0);
    chk("rst_rvalid", {if_rvalid1, ls_rvalid1}, 0);

    // IF read 0x10, RD_LAT=1
    reset = 1'b0; if_req1 = 1'b1; if_addr1 = 32'h10;
    chk("t1_idle_busy", busy1, 0);
    step();
    chk("t1_if_gnt", if_gnt1, 1);
    chk("t1_ls_gnt", ls_gnt1, 0);
    chk("t1_mem", {mem_en1, mem_we1}, 2'b10);
    chk("t1_addr", mem_addr1, 32'h10);
    chk("t1_busy_issue", busy1, 1);
    if_req1 = 1'b0;
    step();
    chk("t1_wait", {if_gnt1, mem_en1, if_rvalid1, busy1}, 4'b0001);
    step();
    chk("t1_rvalid", if_rvalid1, 1);
    chk("t1_rdata", if_rdata1, 32'hDEADBEEF);
    chk("t1_busy_idle", busy1, 0);
    step();
    chk("t1_rvalid_pulse", if_rvalid1, 0);
    chk("t1_rdata_hold", if_rdata1, 32'hDEADBEEF);

    // LS store 0x40 <= 0x1234
    ls_req1 = 1'b1; ls_we1 = 1'b1; ls_addr1 = 32'h40; ls_wdata1 = 32'h1234;
    step();
    chk("t2_gnt", {ls_gnt1, if_gnt1}, 2'b10);
    chk("t2_mem", {mem_en1, mem_we1}, 2'b11);
    chk("t2_addr", mem_addr1, 32'h40);
    chk("t2_wdata", mem_wdata1, 32'h1234);
    ls_req1 = 1'b0; ls_we1 = 1'b0;
    step();
    chk("t2_idle", {busy1, mem_en1, ls_rvalid1}, 0);
    step();
    chk("t2_no_rvalid", ls_rvalid1, 0);

    // Contention after reset: LS, IF, LS, IF
    reset = 1'b1;
    #1;
    chk("t3_rst_busy", busy1, 0);
    step();
    reset = 1'b0;
    if_req1 = 1'b1; if_addr1 = 32'h10; ls_req1 = 1'b1; ls_addr1 = 32'h80;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_ls_gnt", ls_gnt1, (k % 2 == 0));
      chk("t3_if_gnt", if_gnt1, (k % 2 == 1));
      if (k == 3) begin if_req1 = 1'b0; ls_req1 = 1'b0; end
      step(); step();
      chk("t3_ls_rvalid", ls_rvalid1, (k % 2 == 0));
      chk("t3_if_rvalid", if_rvalid1, (k % 2 == 1));
    end
    step();
    chk("t3_done", busy1, 0);
    chk("t3_ls_rdata", ls_rdata1, 32'hCAFEF00D);
    chk("t3_if_rdata", if_rdata1, 32'hDEADBEEF);

    // RD_LAT=3: IF read 0x20, then load 0x80
    if_req3 = 1'b1; if_addr3 = 32'h20;
    step();
    chk("t4_if_gnt", if_gnt3, 1);
    if_req3 = 1'b0;
    step(); step(); step(); step();
    chk("t4_if_rvalid", if_rvalid3, 1);
    chk("t4_if_rdata", if_rdata3, 32'h00205A5A);
    ls_req3 = 1'b1; ls_addr3 = 32'h80;
    step();
    chk("t4_ls_gnt", {ls_gnt3, mem_en3, mem_we3}, 3'b110);
    chk("t4_addr", mem_addr3, 32'h80);
    ls_req3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_wait_rvalid", ls_rvalid3, 0);
      chk("t4_wait_busy", busy3, 1);
    end
    step();
    chk("t4_ls_rvalid", ls_rvalid3, 1);
    chk("t4_ls_rdata", ls_rdata3, 32'hCAFEF00D);
    chk("t4_if_unchanged", if_rdata3, 32'h00205A5A);
    step();
    chk("t4_pulse", ls_rvalid3, 0);

    // Reset during WAIT discards the load; next tie goes to LS
    ls_req3 = 1'b1; ls_addr3 = 32'h84;
    step();
    ls_req3 = 1'b0;
    step();
    chk("t5_in_wait", busy3, 1);
    reset = 1'b1;
    #1;
    chk("t5_outs", {busy3, mem_en3, ls_gnt3, if_gnt3, ls_rvalid3, if_rvalid3}, 0);
    chk("t5_ls_rdata", ls_rdata3, 0);
    chk("t5_if_rdata", if_rdata3, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_no_rvalid", {ls_rvalid3, if_rvalid3}, 0);
    end
    if_req3 = 1'b1; if_addr3 = 32'h10; ls_req3 = 1'b1; ls_addr3 = 32'h80;
    step();
    chk("t5_tie_gnt", {ls_gnt3, if_gnt3}, 2'b10);
    if_req3 = 1'b0; ls_req3 = 1'b0;

    // Random request streams on the RD_LAT=1 instance
    for (int c = 0; c < 300; c++) begin
      step();
      chk("rnd_one_gnt", {if_gnt1 & ls_gnt1}, 0);
      chk("rnd_en_gnt", mem_en1, if_gnt1 | ls_gnt1);
      chk("rnd_one_rvalid", {if_rvalid1 & ls_rvalid1}, 0);
      if (if_rvalid1 || ls_rvalid1) begin
        chk("rnd_rv_pend", pend, 1);
        chk("rnd_rv_owner", {ls_rvalid1, if_rvalid1}, pend_ls ? 2'b10 : 2'b01);
        chk("rnd_rdata", pend_ls ? ls_rdata1 : if_rdata1, mem_val(pend_addr));
        pend = 0;
      end
      if (if_gnt1 || ls_gnt1) begin
        chk("rnd_outstanding", pend, 0);
        if (!mem_we1) begin
          pend = 1; pend_ls = ls_gnt1; pend_addr = mem_addr1;
        end
      end
      if (if_gnt1) if_req1 = 1'b0;
      else if (!if_req1 && $urandom_range(0, 1) == 1) begin
        if_req1 = 1'b1; if_addr1 = 32'($urandom_range(0, 255)) << 2;
      end
      if (ls_gnt1) ls_req1 = 1'b0;
      else if (!ls_req1 && $urandom_range(0, 1) == 1) begin
        ls_req1 = 1'b1; ls_we1 = 1'($urandom_range(0, 1));
        ls_addr1 = 32'($urandom_range(0, 255)) << 2; ls_wdata1 = $urandom;
      end
    end
    if_req1 = 1'b0; ls_req1 = 1'b0;
    step(); step(); step(); step(); step(); step();
    chk("rnd_drained", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
